jtframe_mist_spihost: RTL and testbench
=======================================

# jtframe_mist_spihost

Byte-level SPI master that drives the MiST ARM-controller side of the core's SPI bus (SPI_SCK, SPI_DI, CONF_DATA0, SPI_SS2/3/4) and captures SPI_DO. It lets simulation benches and stand-alone harnesses issue user_io commands (status, joystick, config-string read) and data_io ROM downloads into a MiST top level without the ARM firmware. Frames are built from a valid/ready byte stream. Each transmitted byte returns the byte clocked in simultaneously.

## Interface
- SCK_DIV, 4, clk cycles per SCK half period; legal range 2..255
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- in_valid  in  1  byte offered
- in_ready  out  1  byte accepted when in_valid & in_ready
- in_data  in  8  byte to send, MSB first
- in_sel  in  2  target select, sampled on a frame's first byte only: 0=CONF_DATA0 (user_io), 1=SPI_SS2 (data_io), 2=SPI_SS3 (OSD), 3=SPI_SS4
- in_last  in  1  byte closes the frame
- out_valid  out  1  one-cycle pulse, received byte complete
- out_data  out  8  byte shifted in from SPI_DO
- busy  out  1  frame open or inter-frame gap running
- SPI_SCK  out  1  serial clock, idle low
- SPI_DI  out  1  MOSI into the core
- SPI_DO  in  1  MISO from the core
- CONF_DATA0, SPI_SS2, SPI_SS3, SPI_SS4  out  1 each  active-low selects

## Operation
- SPI mode 0: SCK idles low. MOSI changes after falling edges. SPI_DO is captured on the clk edge where SPI_SCK goes 0→1.
- States: IDLE → SETUP → SHIFT → (WAIT | HOLD) → GAP → IDLE.
- IDLE: in_ready=1, all selects high. On accept: latch in_sel and in_data, assert the selected select, and drive bit7 on SPI_DI. Enter SETUP.
- SETUP: SCK low for SCK_DIV cycles.
- SHIFT: 8 bits, each SCK high SCK_DIV cycles then low SCK_DIV cycles. A 3-bit bit counter and an 8-bit divider counter run here. The received-data shift register fills LSB-in.
- After the 8th falling edge: pulse out_valid and update out_data.
  - in_last=0: go to WAIT with in_ready=1. The select stays low and SCK stays low indefinitely. An accepted byte re-enters SETUP; in_sel is ignored.
  - in_last=1: go to HOLD (select low, SCK low, SCK_DIV cycles). Then deassert the select and enter GAP for 2·SCK_DIV cycles, with in_ready=0. Then return to IDLE.
- busy=1 in every state except IDLE.
- Only one select is ever low at a time.

## Timing
- Reset (rst_n low at a clk edge) sets next cycle: selects=1, SPI_SCK=0, SPI_DI=0, in_ready=0, out_valid=0, out_data=0x00, busy=0. in_ready rises on the first cycle after rst_n returns high.
- Reset mid-frame: selects rise on the reset edge and the partial byte is discarded, with no out_valid.
- Acceptance cycle = 0. Select low and SPI_DI=bit7 at cycle 1.
- Rising edges fall at 1+(2k+1)·SCK_DIV and falling edges at 1+(2k+2)·SCK_DIV, for k=0..7.
- out_valid fires at cycle 1+16·SCK_DIV. in_ready for a continuation byte asserts the same cycle.
- Back-to-back bytes: accepting in the out_valid cycle keeps the select low continuously. The next byte uses the same cycle offsets from its own acceptance.
- Last byte: select high at 1+17·SCK_DIV, in_ready=1 at 1+19·SCK_DIV.
- in_valid while in_ready=0 is ignored and never latched.

## Test plan
- Reset mid-byte, SCK_DIV=4: rst_n low 3 cycles during SHIFT on sel 1 → SPI_SS2=1, SPI_SCK=0 the next cycle. No out_valid. in_ready=1 one cycle after release.
- Single-byte loopback, SCK_DIV=4: SPI_DO tied to SPI_DI; send 0xA5, sel 0, last=1 at cycle 0. Required:
  - CONF_DATA0 low cycles 1..68.
  - Rising edges at 5,13,…,61.
  - out_valid with out_data=0xA5 at cycle 65.
  - CONF_DATA0 high at 69, in_ready=1 at 77, busy low at 77.
- data_io frame: sel 1, bytes 0x54, 0x12, 0x34(last), sent back-to-back → SPI_SS2 low continuously across 24 rising edges. MOSI bit sequence matches the bytes MSB-first. CONF_DATA0, SPI_SS3 and SPI_SS4 stay 1.
- Read-back: the SPI_DO model drives 0x3C MSB-first, changing on falling SCK; send 0x14 then 0x00(last) → second out_data=0x3C.
- Stall: first byte last=0, then in_valid low 100 cycles → SCK=0, select low and in_ready=1 throughout. The next byte shifts normally with the same cycle offsets.
- Select latch: continuation byte offered with in_sel=2 → SPI_SS3 stays 1 and the original select stays low.

Source files
------------

// File: rtl/jtframe_mist_spihost.sv
// Byte-level SPI mode-0 master that stands in for the MiST ARM controller on the core's SPI bus.
// Frames come from a valid/ready byte stream; every byte sent returns the byte clocked in from SPI_DO.
module jtframe_mist_spihost #(
  parameter int SCK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic [1:0] in_sel,
  input  logic       in_last,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       busy,
  output logic       SPI_SCK,
  output logic       SPI_DI,
  input  logic       SPI_DO,
  output logic       CONF_DATA0,
  output logic       SPI_SS2,
  output logic       SPI_SS3,
  output logic       SPI_SS4
);
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_WAIT, S_HOLD, S_GAP} state_t;

  localparam logic [7:0] DIV_LAST = 8'(SCK_DIV - 1);

  state_t     state, state_nx;
  logic [7:0] div_cnt, div_cnt_nx;
  logic [2:0] bit_cnt, bit_cnt_nx;
  logic [7:0] tx_sr, tx_sr_nx;
  logic [7:0] rx_sr, rx_sr_nx;
  logic [7:0] rx_byte, rx_byte_nx;
  logic [3:0] ss_n, ss_n_nx;
  logic       last, last_nx;
  logic       sck, sck_nx;
  logic       mosi, mosi_nx;
  logic       ready, ready_nx;
  logic       ov, ov_nx;
  logic       accept, div_end;

  assign accept  = in_valid & ready;
  assign div_end = (div_cnt == DIV_LAST);

  always_comb begin
    state_nx   = state;
    div_cnt_nx = div_cnt + 8'd1;
    bit_cnt_nx = bit_cnt;
    tx_sr_nx   = tx_sr;
    rx_sr_nx   = rx_sr;
    rx_byte_nx = rx_byte;
    ss_n_nx    = ss_n;
    last_nx    = last;
    sck_nx     = sck;
    mosi_nx    = mosi;
    ov_nx      = 1'b0;
    unique case (state)
      S_IDLE: begin
        div_cnt_nx = 8'd0;
        ss_n_nx    = 4'hF;
        sck_nx     = 1'b0;
        if (accept) begin
          ss_n_nx  = ~(4'b0001 << in_sel);
          tx_sr_nx = in_data;
          mosi_nx  = in_data[7];
          last_nx  = in_last;
          state_nx = S_SETUP;
        end
      end
      // select stays asserted; the target was fixed by the frame's first byte
      S_WAIT: begin
        div_cnt_nx = 8'd0;
        sck_nx     = 1'b0;
        if (accept) begin
          tx_sr_nx = in_data;
          mosi_nx  = in_data[7];
          last_nx  = in_last;
          state_nx = S_SETUP;
        end
      end
      S_SETUP: begin
        if (div_end) begin
          div_cnt_nx = 8'd0;
          bit_cnt_nx = 3'd0;
          sck_nx     = 1'b1;
          rx_sr_nx   = {rx_sr[6:0], SPI_DO};
          state_nx   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (div_end) begin
          div_cnt_nx = 8'd0;
          if (sck) begin
            sck_nx = 1'b0;
            if (bit_cnt == 3'd7) begin
              ov_nx      = 1'b1;
              rx_byte_nx = rx_sr;
              state_nx   = last ? S_HOLD : S_WAIT;
            end else begin
              tx_sr_nx = {tx_sr[6:0], 1'b0};
              mosi_nx  = tx_sr[6];
            end
          end else begin
            sck_nx     = 1'b1;
            rx_sr_nx   = {rx_sr[6:0], SPI_DO};
            bit_cnt_nx = bit_cnt + 3'd1;
          end
        end
      end
      S_HOLD: begin
        if (div_end) begin
          div_cnt_nx = 8'd0;
          bit_cnt_nx = 3'd0;
          ss_n_nx    = 4'hF;
          state_nx   = S_GAP;
        end
      end
      // gap is two divider periods; bit_cnt[0] marks the second one so div_cnt stays 8 bits
      S_GAP: begin
        if (div_end) begin
          div_cnt_nx = 8'd0;
          if (bit_cnt[0]) state_nx = S_IDLE;
          else            bit_cnt_nx = 3'd1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
    ready_nx = (state_nx == S_IDLE) || (state_nx == S_WAIT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      div_cnt <= 8'd0;
      bit_cnt <= 3'd0;
      tx_sr   <= 8'd0;
      rx_sr   <= 8'd0;
      rx_byte <= 8'd0;
      ss_n    <= 4'hF;
      last    <= 1'b0;
      sck     <= 1'b0;
      mosi    <= 1'b0;
      ready   <= 1'b0;
      ov      <= 1'b0;
    end else begin
      state   <= state_nx;
      div_cnt <= div_cnt_nx;
      bit_cnt <= bit_cnt_nx;
      tx_sr   <= tx_sr_nx;
      rx_sr   <= rx_sr_nx;
      rx_byte <= rx_byte_nx;
      ss_n    <= ss_n_nx;
      last    <= last_nx;
      sck     <= sck_nx;
      mosi    <= mosi_nx;
      ready   <= ready_nx;
      ov      <= ov_nx;
    end
  end

  assign in_ready   = ready;
  assign out_valid  = ov;
  assign out_data   = rx_byte;
  assign busy       = (state != S_IDLE);
  assign SPI_SCK    = sck;
  assign SPI_DI     = mosi;
  assign CONF_DATA0 = ss_n[0];
  assign SPI_SS2    = ss_n[1];
  assign SPI_SS3    = ss_n[2];
  assign SPI_SS4    = ss_n[3];
endmodule

// File: tb/tb_jtframe_mist_spihost.sv
// Bench for jtframe_mist_spihost: cycle-exact directed checks plus random frames against a behavioural SPI slave.
module tb_jtframe_mist_spihost;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic [1:0] in_sel = 2'd0;
  logic       in_ready, out_valid, busy;
  logic [7:0] out_data;
  logic       SPI_SCK, SPI_DI, SPI_DO, CONF_DATA0, SPI_SS2, SPI_SS3, SPI_SS4;
  int         checks = 0;
  int         failures = 0;

  jtframe_mist_spihost #(.SCK_DIV(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel), .in_last(in_last),
    .out_valid(out_valid), .out_data(out_data), .busy(busy),
    .SPI_SCK(SPI_SCK), .SPI_DI(SPI_DI), .SPI_DO(SPI_DO),
    .CONF_DATA0(CONF_DATA0), .SPI_SS2(SPI_SS2), .SPI_SS3(SPI_SS3), .SPI_SS4(SPI_SS4)
  );

  always #5 clk = ~clk;

  // Behavioural slave: loopback, or returns slv_mem bytes MSB-first, shifting after each falling SCK.
  logic       loop_mode = 1'b1;
  logic [7:0] slv_mem [16];
  logic [7:0] fr_tx [4];
  logic [3:0] slv_idx = 4'd0;
  logic [2:0] slv_bit = 3'd0;
  logic       sck_q = 1'b0;
  logic [3:0] ss_prev = 4'hF;
  logic [3:0] ss;
  int         ov_cnt = 0;
  int         fall_cnt [4] = '{0, 0, 0, 0};
  logic       mosi_q [$];
  logic [3:0] rise_ss_q [$];
  logic [7:0] rx_q [$];

  assign ss     = {SPI_SS4, SPI_SS3, SPI_SS2, CONF_DATA0};
  assign SPI_DO = loop_mode ? SPI_DI : slv_mem[slv_idx][3'd7 - slv_bit];

  always @(negedge clk) begin
    sck_q   <= SPI_SCK;
    ss_prev <= ss;
    if (&ss) begin
      slv_idx <= 4'd0;
      slv_bit <= 3'd0;
    end else if (sck_q && !SPI_SCK) begin
      slv_bit <= slv_bit + 3'd1;
      if (slv_bit == 3'd7) slv_idx <= slv_idx + 4'd1;
    end
    if (!sck_q && SPI_SCK) begin
      mosi_q.push_back(SPI_DI);
      rise_ss_q.push_back(ss);
    end
    if (out_valid === 1'b1) begin
      ov_cnt <= ov_cnt + 1;
      rx_q.push_back(out_data);
    end
    for (int i = 0; i < 4; i++)
      if (ss_prev[i] && !ss[i]) fall_cnt[i] <= fall_cnt[i] + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Offer one byte; junk bytes are waved at the DUT while it is not ready and must be ignored.
  task automatic offer(input logic [7:0] d, input logic [1:0] s, input logic l, input bit junk);
    int n;
    n = 0;
    in_valid = 1'b0;
    if (junk) repeat ($urandom_range(0, 3)) @(negedge clk);
    while (in_ready !== 1'b1 && n < 4000) begin
      in_valid = junk ? 1'($urandom_range(0, 1)) : 1'b0;
      in_data  = 8'($urandom);
      in_sel   = 2'($urandom);
      in_last  = 1'($urandom);
      @(negedge clk);
      n++;
    end
    chk("offer_ready", in_ready, 1'b1);
    in_valid = 1'b1; in_data = d; in_sel = s; in_last = l;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Cycle-exact check of one byte from its acceptance; fs is the select owning the frame.
  task automatic byte_timing(input logic [7:0] d, input logic [1:0] s, input logic l,
                             input logic [1:0] fs, input logic [7:0] erx);
    int         ncyc, m;
    logic [3:0] sel_low;
    sel_low = ~(4'b0001 << fs);
    ncyc = l ? 2 + 19 * D : 3 + 16 * D;
    chk("bt_ready_start", in_ready, 1'b1);
    in_valid = 1'b1; in_data = d; in_sel = s; in_last = l;
    for (int c = 1; c < ncyc; c++) begin
      @(negedge clk);
      if (c == 1) begin
        in_valid = 1'b0; in_data = 8'($urandom); in_sel = 2'($urandom);
      end
      m = (c - 1) / D;
      chk($sformatf("bt_sck@%0d", c), SPI_SCK, (m % 2 == 1) && (m < 16));
      chk($sformatf("bt_sel@%0d", c), ss, (l && c > 17 * D) ? 4'hF : sel_low);
      chk($sformatf("bt_ov@%0d", c), out_valid, c == 1 + 16 * D);
      chk($sformatf("bt_ready@%0d", c), in_ready, l ? (c >= 1 + 19 * D) : (c >= 1 + 16 * D));
      chk($sformatf("bt_busy@%0d", c), busy, l ? (c < 1 + 19 * D) : 1'b1);
      if (c < 1 + 16 * D) chk($sformatf("bt_mosi@%0d", c), SPI_DI, d[7 - (c - 1) / (2 * D)]);
      if (c == 1 + 16 * D) chk("bt_rx", out_data, erx);
    end
  endtask

  // Send fr_tx[0..n-1] as one frame on select s and compare against the slave-side view.
  task automatic run_frame(input logic [1:0] s, input int n, input bit junk);
    int         f0 [4];
    int         bound;
    logic [7:0] b;
    logic [3:0] exp_ss;
    exp_ss = ~(4'b0001 << s);
    mosi_q.delete(); rise_ss_q.delete(); rx_q.delete();
    foreach (f0[i]) f0[i] = fall_cnt[i];
    for (int i = 0; i < n; i++)
      offer(fr_tx[i], (i == 0) ? s : 2'($urandom), i == n - 1, junk);
    bound = 0;
    while (busy && bound < 4000) begin
      @(negedge clk);
      bound++;
    end
    chk("fr_done", busy, 1'b0);
    chk("fr_nbits", mosi_q.size(), 8 * n);
    chk("fr_nrx", rx_q.size(), n);
    if (mosi_q.size() == 8 * n && rx_q.size() == n) begin
      for (int i = 0; i < n; i++) begin
        b = 8'h00;
        for (int j = 0; j < 8; j++) b = {b[6:0], mosi_q[8 * i + j]};
        chk($sformatf("fr_tx%0d", i), b, fr_tx[i]);
        chk($sformatf("fr_rx%0d", i), rx_q[i], slv_mem[i]);
      end
    end
    foreach (rise_ss_q[k]) chk($sformatf("fr_ss%0d", k), rise_ss_q[k], exp_ss);
    for (int j = 0; j < 4; j++) chk($sformatf("fr_fall%0d", j), fall_cnt[j] - f0[j], j == s);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] s0;
    logic [7:0] d0;
    logic [3:0] sl;
    int         ov0;
    foreach (slv_mem[i]) slv_mem[i] = 8'h00;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_ss", ss, 4'hF);
    chk("rst_sck", SPI_SCK, 1'b0);
    chk("rst_di", SPI_DI, 1'b0);
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_ov", out_valid, 1'b0);
    chk("rst_od", out_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", in_ready, 1'b1);
    chk("rel_busy", busy, 1'b0);

    // single-byte loopback, exact cycle offsets
    byte_timing(8'hA5, 2'd0, 1'b1, 2'd0, 8'hA5);

    // stall in WAIT, then continuation offered with in_sel=2
    s0 = 2'($urandom_range(0, 2));
    if (s0 == 2'd2) s0 = 2'd3;
    sl = ~(4'b0001 << s0);
    d0 = 8'($urandom);
    byte_timing(d0, s0, 1'b0, s0, d0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("stall_sck", SPI_SCK, 1'b0);
      chk("stall_sel", ss, sl);
      chk("stall_ready", in_ready, 1'b1);
      chk("stall_busy", busy, 1'b1);
    end
    d0 = 8'($urandom);
    byte_timing(d0, 2'd2, 1'b1, s0, d0);

    // reset mid-byte on data_io
    ov0 = ov_cnt;
    offer(8'h5A, 2'd1, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    chk("mid_sel_low", SPI_SS2, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_ss2", SPI_SS2, 1'b1);
    chk("mid_sck", SPI_SCK, 1'b0);
    chk("mid_ready", in_ready, 1'b0);
    chk("mid_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rel_ready", in_ready, 1'b1);
    repeat (80) @(negedge clk);
    chk("mid_no_ov", ov_cnt - ov0, 0);

    // read-back through the slave model
    loop_mode = 1'b0;
    slv_mem[0] = 8'($urandom); slv_mem[1] = 8'h3C;
    fr_tx[0] = 8'h14; fr_tx[1] = 8'h00;
    run_frame(2'd0, 2, 1'b0);
    if (rx_q.size() == 2) chk("rb_3c", rx_q[1], 8'h3C);

    // data_io download frame, back-to-back bytes
    foreach (slv_mem[i]) slv_mem[i] = 8'($urandom);
    fr_tx[0] = 8'h54; fr_tx[1] = 8'h12; fr_tx[2] = 8'h34;
    run_frame(2'd1, 3, 1'b0);
    chk("dio_rises", rise_ss_q.size(), 24);

    // random frames with junk offers while not ready
    for (int f = 0; f < 6; f++) begin
      foreach (slv_mem[i]) slv_mem[i] = 8'($urandom);
      foreach (fr_tx[i]) fr_tx[i] = 8'($urandom);
      run_frame(2'($urandom), $urandom_range(1, 4), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
